// File: rtl/fma16_round_pack.sv
// fma16_round_pack: final stage of the fma16 datapath.
// Takes the normalized significand and the normalizer's shift count, rounds
// to 11 significant bits under the requested mode, detects overflow and
// underflow, and packs an IEEE binary16 result with {overflow, underflow,
// inexact} flags. Two register stages with a valid/ready handshake.
//
// Handshake: a beat moves across an interface on any rising edge where both
// valid and ready are high. Valid is never withdrawn and payload never
// changes while valid is high and ready is low. Each stage advances when it
// is empty or its downstream consumer takes its beat this cycle, so a full
// pipeline streams one beat per cycle and stalls without loss.
module fma16_round_pack #(
    parameter int BIAS   = 15,
    parameter int EMAX_B = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [33:0] in_sm,
    input  logic [6:0]  in_count,
    input  logic        in_zero,
    input  logic        in_special,
    input  logic [15:0] in_special_res,
    input  logic [1:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_flags
);

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;

    localparam logic [4:0]        EXP_INF = 5'(2 * BIAS + 1);
    localparam logic [4:0]        EXP_MAX = 5'(EMAX_B);
    localparam logic signed [8:0] EMAX_S  = 9'(EMAX_B);

    // Pipeline control
    logic s1_valid_q;
    logic out_valid_q;
    logic s1_adv;
    logic s2_adv;

    // Stage 1 payload
    logic               s1_sign_q,  s1_sign_d;
    logic signed [8:0]  s1_er_q,    s1_er_d;
    logic [9:0]         s1_frac_q,  s1_frac_d;
    logic               s1_inc_q,   s1_inc_d;
    logic               s1_nx_q,    s1_nx_d;
    logic               s1_zero_q;
    logic               s1_special_q;
    logic [15:0]        s1_special_res_q;
    logic [1:0]         s1_rm_q;

    // Stage 2 payload
    logic [15:0]        out_result_q, out_result_d;
    logic [2:0]         out_flags_q,  out_flags_d;

    // Stage 2 working signals
    logic [10:0]        round_sum;
    logic signed [8:0]  er_rnd;
    logic [9:0]         frac_rnd;
    logic               of_hit;
    logic               uf_hit;
    logic               to_inf;

    // The leading 1 is implied by normalization; only the fraction below it
    // carries information into the packed result.
    logic unused_lead_one;
    assign unused_lead_one = in_sm[33];

    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    // Stage 1: rebias the exponent and decide the rounding increment
    always_comb begin
        logic lsb_bit;
        logic guard_bit;
        logic sticky_bit;
        s1_sign_d  = in_sign;
        s1_er_d    = $signed({in_exp[7], in_exp}) - $signed({{2{in_count[6]}}, in_count});
        s1_frac_d  = in_sm[32:23];
        lsb_bit    = in_sm[23];
        guard_bit  = in_sm[22];
        sticky_bit = |in_sm[21:0];
        s1_nx_d    = guard_bit | sticky_bit;
        case (in_rm)
            RM_RZ:   s1_inc_d = 1'b0;
            RM_RNE:  s1_inc_d = guard_bit & (lsb_bit | sticky_bit);
            RM_RDN:  s1_inc_d = in_sign & (guard_bit | sticky_bit);
            default: s1_inc_d = !in_sign & (guard_bit | sticky_bit);
        endcase
    end

    // Stage 2: apply the increment, then classify and pack
    always_comb begin
        round_sum = {1'b0, s1_frac_q} + {10'b0, s1_inc_q};
        er_rnd    = round_sum[10] ? s1_er_q + 9'sd1 : s1_er_q;
        frac_rnd  = round_sum[9:0];
        of_hit    = er_rnd > EMAX_S;
        uf_hit    = er_rnd <= 9'sd0;
        case (s1_rm_q)
            RM_RNE:  to_inf = 1'b1;
            RM_RDN:  to_inf = s1_sign_q;
            RM_RZ:   to_inf = 1'b0;
            default: to_inf = !s1_sign_q;
        endcase

        out_result_d = {s1_sign_q, er_rnd[4:0], frac_rnd};
        out_flags_d  = {2'b00, s1_nx_q};
        if (s1_special_q) begin
            out_result_d = s1_special_res_q;
            out_flags_d  = 3'b000;
        end else if (s1_zero_q) begin
            out_result_d = {s1_sign_q, 15'b0};
            out_flags_d  = 3'b000;
        end else if (of_hit) begin
            out_result_d = to_inf ? {s1_sign_q, EXP_INF, 10'h000}
                                  : {s1_sign_q, EXP_MAX, 10'h3FF};
            out_flags_d  = 3'b101;
        end else if (uf_hit) begin
            out_result_d = {s1_sign_q, 15'b0};
            out_flags_d  = 3'b011;
        end
    end

    // Stage valids: flush empties both stages, otherwise advance on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
        end
    end

    // Stage 1 payload captured on input transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sign_q        <= 1'b0;
            s1_er_q          <= 9'sd0;
            s1_frac_q        <= 10'b0;
            s1_inc_q         <= 1'b0;
            s1_nx_q          <= 1'b0;
            s1_zero_q        <= 1'b0;
            s1_special_q     <= 1'b0;
            s1_special_res_q <= 16'h0000;
            s1_rm_q          <= 2'b00;
        end else if (s1_adv && in_valid) begin
            s1_sign_q        <= s1_sign_d;
            s1_er_q          <= s1_er_d;
            s1_frac_q        <= s1_frac_d;
            s1_inc_q         <= s1_inc_d;
            s1_nx_q          <= s1_nx_d;
            s1_zero_q        <= in_zero;
            s1_special_q     <= in_special;
            s1_special_res_q <= in_special_res;
            s1_rm_q          <= in_rm;
        end
    end

    // Output payload loads only when stage 2 advances, so it holds under stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_result_q <= 16'h0000;
            out_flags_q  <= 3'b000;
        end else if (s2_adv && s1_valid_q) begin
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_fma16_round_pack.sv
// Testbench for fma16_round_pack: directed corner cases, backpressure,
// flush, mid-stream reset and a randomized stream against a reference model.
module tb_fma16_round_pack;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [33:0] in_sm;
    logic [6:0]  in_count;
    logic        in_zero;
    logic        in_special;
    logic [15:0] in_special_res;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    fma16_round_pack dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_sm          (in_sm),
        .in_count       (in_count),
        .in_zero        (in_zero),
        .in_special     (in_special),
        .in_special_res (in_special_res),
        .in_rm          (in_rm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    logic [18:0] exp_q[$];
    logic        last_acc;
    logic        saw_stall;
    logic        hold_pend;
    logic [18:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: round the 11-bit significand by comparing the discarded
    // remainder against one half ulp, then classify the final exponent.
    function automatic logic [18:0] model(input logic sign, input logic [7:0] exp8,
                                          input logic [33:0] sm, input logic [6:0] cnt,
                                          input logic zero, input logic special,
                                          input logic [15:0] sres, input logic [1:0] rm);
        int   e;
        int   top;
        int   rem;
        int   half;
        logic up;
        logic inexact;
        logic inf_dir;
        if (special) return {sres, 3'b000};
        if (zero) return {sign, 15'b0, 3'b000};
        e       = int'($signed(exp8)) - int'($signed(cnt));
        top     = int'(sm[33:23]);
        rem     = int'(sm[22:0]);
        half    = 1 << 22;
        inexact = (rem != 0);
        case (rm)
            2'd0:    up = 1'b0;
            2'd1:    up = (rem > half) || (rem == half && (top % 2) == 1);
            2'd2:    up = sign && inexact;
            default: up = !sign && inexact;
        endcase
        if (up) top = top + 1;
        if (top == 2048) begin
            top = 1024;
            e   = e + 1;
        end
        if (e > 30) begin
            inf_dir = (rm == 2'd1) || (rm == 2'd2 && sign) || (rm == 2'd3 && !sign);
            if (inf_dir) return {sign, 15'h7C00, 3'b101};
            return {sign, 15'h7BFF, 3'b101};
        end
        if (e <= 0) return {sign, 15'b0, 3'b011};
        return {sign, 5'(e), 10'(top - 1024), 2'b00, inexact};
    endfunction

    // One clock: evaluate the handshakes that will happen at the coming
    // rising edge, update the scoreboard, then move to the next falling edge.
    task automatic step();
        logic [18:0] want;
        #1;
        last_acc = 1'b0;
        if (reset_n) begin
            if (!in_ready) saw_stall = 1'b1;
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out_result, out_flags}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'({out_result, out_flags}), 32'h7FFFF);
                end else begin
                    want = exp_q.pop_front();
                    check("out", 32'({out_result, out_flags}), 32'(want));
                    n_out++;
                end
            end
            hold_pend = out_valid && !out_ready && !flush;
            held      = {out_result, out_flags};
            last_acc  = in_valid && in_ready && !flush;
            if (last_acc) begin
                exp_q.push_back(model(in_sign, in_exp, in_sm, in_count, in_zero,
                                      in_special, in_special_res, in_rm));
            end
            if (flush) exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic sign, input logic [7:0] e, input logic [33:0] sm,
                            input logic [6:0] cnt, input logic zero, input logic special,
                            input logic [15:0] sres, input logic [1:0] rm);
        in_sign = sign; in_exp = e; in_sm = sm; in_count = cnt;
        in_zero = zero; in_special = special; in_special_res = sres; in_rm = rm;
    endtask

    task automatic rand_beat();
        logic [9:0]  frac;
        logic [22:0] low;
        int          sel;
        frac = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
        sel  = $urandom_range(0, 4);
        case (sel)
            0:       low = 23'h400000;
            1:       low = 23'h000000;
            2:       low = 23'h7FFFFF;
            3:       low = 23'h400001;
            default: low = 23'($urandom);
        endcase
        in_sign        = 1'($urandom);
        in_exp         = 8'($urandom_range(0, 70) - 30);
        in_count       = 7'($urandom_range(0, 33) - 12);
        in_sm          = {1'b1, frac, low};
        in_zero        = ($urandom_range(0, 15) == 0);
        in_special     = ($urandom_range(0, 15) == 0);
        in_special_res = 16'($urandom);
        in_rm          = 2'($urandom);
    endtask

    // Single beat through an empty pipeline with a fixed expected result
    task automatic run_one(input string tag, input logic sign, input logic [7:0] e,
                           input logic [33:0] sm, input logic [6:0] cnt, input logic zero,
                           input logic special, input logic [15:0] sres,
                           input logic [1:0] rm, input logic [18:0] want);
        set_beat(sign, e, sm, cnt, zero, special, sres, rm);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_lat2"}, 32'(out_valid), 32'd1);
        check(tag, 32'({out_result, out_flags}), 32'(want));
        step();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int sent;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hold_pend = 1'b0;
        held      = '0;
        last_acc  = 1'b0;
        saw_stall = 1'b0;
        set_beat(1'b0, 8'd0, 34'd0, 7'd0, 1'b0, 1'b0, 16'h0, 2'd0);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'h0000);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed corners
        run_one("t1_one",      1'b0, 8'd3,   34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd1, {16'h3C00, 3'b000});
        run_one("t2_rne",      1'b0, 8'd3,   34'h2_00C0_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd1, {16'h3C02, 3'b001});
        run_one("t2_rz",       1'b0, 8'd3,   34'h2_00C0_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd0, {16'h3C01, 3'b001});
        run_one("t3_carry",    1'b0, 8'd3,   34'h3_FFC0_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd1, {16'h4000, 3'b001});
        run_one("t4_of_rne",   1'b0, 8'd19,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd1, {16'h7C00, 3'b101});
        run_one("t4_of_rz",    1'b1, 8'd19,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd0, {16'hFBFF, 3'b101});
        run_one("t4_of_rdn_n", 1'b1, 8'd19,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd2, {16'hFC00, 3'b101});
        run_one("t4_of_rdn_p", 1'b0, 8'd19,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd2, {16'h7BFF, 3'b101});
        run_one("t4_of_rup_n", 1'b1, 8'd19,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd3, {16'hFBFF, 3'b101});
        run_one("t4_uf",       1'b0, 8'hF4,  34'h2_0000_0000, 7'h74, 1'b0, 1'b0, 16'h0, 2'd1, {16'h0000, 3'b011});
        run_one("t5_zero",     1'b1, 8'd19,  34'h2_0000_0000, 7'h74, 1'b1, 1'b0, 16'h0, 2'd1, {16'h8000, 3'b000});
        run_one("t5_special",  1'b1, 8'd19,  34'h2_0000_0000, 7'h74, 1'b1, 1'b1, 16'h7E00, 2'd1, {16'h7E00, 3'b000});

        // Backpressure: 8 beats with out_ready cycling 1-0-0-1
        base      = n_out;
        sent      = 0;
        saw_stall = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 64 && sent < 8; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            if (last_acc) begin
                sent++;
                if (sent < 8) rand_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        drain();
        check("bp_stall_seen", 32'(saw_stall), 32'd1);
        check("bp_count", 32'(n_out - base), 32'd8);

        // Flush with two beats in flight plus a same-edge beat that must vanish
        out_ready = 1'b0;
        sent      = 0;
        rand_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 8 && sent < 2; c++) begin
            step();
            if (last_acc) begin
                sent++;
                rand_beat();
            end
        end
        flush = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("flush_no_out", 32'(out_valid), 32'd0);
            step();
        end

        // Reset mid-stream: outputs go back to reset values at once
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'h0000);
        check("mid_rst_flags", 32'(out_flags), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        hold_pend = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_idle", 32'(out_valid), 32'd0);

        // Randomized stream with random stalls and occasional flushes
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    rand_beat();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 59) == 0);
            if (flush) out_ready = 1'b0;
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
